rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Shares the single write port of the 8-bit, 16-entry accumulator-style register file between N independent writers: ALU writeback, load unit and debug/host port. Each writer presents a valid/ready write request. The block grants one request per cycle by round-robin and drives the register file's RegWrite/AccWrite/reg_index/writeValue from a registered output stage. It sits between the writeback sources and the register file in the top-level datapath.

Parameters:
W, 8, data width; matches register file width.
D, 4, register index width (2**D registers; index 0 is the accumulator).
N, 3, number of requesters (2..8).

Ports:
CLK  input  1  clock; all state updates on posedge.
RST_N  input  1  asynchronous active-low reset.
arb_en  input  1  1 = grants allowed; 0 = stall, no grants, pending requests held by requesters.
req_valid  input  N  per-requester write request valid.
req_acc  input  N  per-requester: 1 = target is accumulator (register 0).
req_index  input  N*D  per-requester target register index, packed, requester i at [i*D +: D].
req_data  input  N*W  per-requester write data, packed, requester i at [i*W +: W].
req_ready  output  N  one-hot grant; request i accepted in the cycle where req_valid[i] & req_ready[i].
RegWrite  output  1  to register file: general register write.
AccWrite  output  1  to register file: accumulator write.
reg_index  output  D  to register file: write index.
writeValue  output  W  to register file: write data.

Behaviour:
- Reset (RST_N=0, asynchronous): RegWrite=0, AccWrite=0, reg_index=0, writeValue=0, round-robin pointer ptr=0. The req_ready outputs are combinational and are 0 while reset is asserted. Any request in flight at reset assertion is dropped; the requester retries after reset.
- Grant logic is combinational in the same cycle.
  - If arb_en=0, req_ready is all 0.
  - Otherwise, search indices ptr, ptr+1, ... wrapping mod N, and grant the first i with req_valid[i]=1. req_ready is one-hot or 0, never multiple bits.
  - req_ready[i] does not depend on req_valid[j] for j with lower rotated priority than i.
- Pointer update:
  - On a grant to i, ptr <= (i+1) mod N.
  - With no grant, ptr holds.
  - The pointer wraps from N-1 to 0.
- Output stage, one-cycle latency. On the posedge after a handshake on requester i:
  - If req_acc[i]=1: AccWrite=1, RegWrite=0, reg_index=0, writeValue=req_data[i].
  - If req_acc[i]=0 and req_index[i]!=0: RegWrite=1, AccWrite=0, reg_index=req_index[i], writeValue=req_data[i].
  - If req_acc[i]=0 and req_index[i]==0: the write is normalised to AccWrite=1, RegWrite=0. RegWrite and AccWrite are never both 1.
  - If there is no handshake, RegWrite=0 and AccWrite=0. reg_index and writeValue hold their last values.
- Back-to-back: a requester holding valid is re-granted only after every other valid requester has been served once (fairness bound: at most N-1 cycles of wait while arb_en=1).
- Simultaneous valid on all N: grants issue in rotated order, one per cycle, N writes in N consecutive cycles, no bubbles.
- arb_en falling mid-burst: the grant stops that cycle and the already-registered write still issues next cycle. The pointer is preserved and the rotation resumes when arb_en rises.
- Requesters must hold req_acc, req_index and req_data stable while valid and not ready.

Optional Feature:
Macro RF_ARB_STATS_EN.
- Defined: adds output grant_cnt (N*16 bits). Each 16-bit counter increments on a handshake for its requester, saturates at 16'hFFFF, and resets to 0 on RST_N.
- Undefined: the port and counters are absent. Grant behaviour is identical in both cases.

Decomposition:
- Package rf_arb_pkg holds:
  - constants RF_W=8, RF_D=4, RF_ARB_N=3;
  - typedef rf_req_t struct {acc, index[D], data[W]};
  - typedef rf_ptr_t logic [$clog2(N)-1:0].
- Sub-module rr_pick: purely combinational rotate-priority picker. Inputs: valid[N], ptr. Outputs: onehot grant[N], grant_idx, any.
- The top holds the pointer, output registers and optional stats.

Test Plan:
- Reset: hold RST_N=0 with all req_valid=1 -> req_ready=0, RegWrite=AccWrite=0. After release, first grant goes to requester 0.
- All valid from ptr=0, indices 3, 5, 7 and data 8'h11, 8'h22, 8'h33 -> RegWrite pulses on 3 consecutive cycles with reg_index 3, 5, 7 and writeValue 11, 22, 33, each one cycle after its grant.
- Accumulator requests:
  - req_acc[1]=1 with data 8'hA5 -> AccWrite=1, RegWrite=0, reg_index=0, writeValue=A5.
  - req_acc=0 with index 0 and data 8'h5A -> AccWrite=1, RegWrite=0.
- Fairness: requesters 0 and 2 held valid continuously -> grants alternate 0, 2, 0, 2 with no requester waiting more than 1 cycle.
- Stall: all valid, arb_en dropped after the first grant -> exactly one write issues, then none. Raising arb_en resumes with requester 1.
- Async reset mid-burst: RST_N pulsed between clocks -> outputs clear immediately and ptr restarts at 0. With RF_ARB_STATS_EN defined, grant_cnt clears to 0 and a counter forced to 16'hFFFF does not wrap.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the register-file write arbiter.
package rf_arb_pkg;

  localparam int RF_W     = 8;
  localparam int RF_D     = 4;
  localparam int RF_ARB_N = 3;

  typedef struct packed {
    logic            acc;
    logic [RF_D-1:0] index;
    logic [RF_W-1:0] data;
  } rf_req_t;

  typedef logic [$clog2(RF_ARB_N)-1:0] rf_ptr_t;

endpackage

// File: rtl/rf_write_arbiter_rr_pick.sv
// Rotate-priority picker: first valid requester at or after ptr, wrapping mod N.
import rf_arb_pkg::*;

module rr_pick #(
  parameter int N  = RF_ARB_N,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  int unsigned cand;

  // Walk the rotated order once; the first valid hit wins, later ones are ignored.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = 32'(ptr) + 32'(k);
      if (cand >= 32'(N)) cand = cand - 32'(N);
      if (!any && valid[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = PW'(cand);
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Grants are combinational; the register-file strobes come from a one-cycle
// registered output stage. Optional macro RF_ARB_STATS_EN adds per-requester
// saturating grant counters on port grant_cnt.
import rf_arb_pkg::*;

module rf_write_arbiter #(
  parameter int W = RF_W,
  parameter int D = RF_D,
  parameter int N = RF_ARB_N
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           arb_en,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_acc,
  input  logic [N*D-1:0] req_index,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           RegWrite,
  output logic           AccWrite,
  output logic [D-1:0]   reg_index,
  output logic [W-1:0]   writeValue
`ifdef RF_ARB_STATS_EN
  ,output logic [N*16-1:0] grant_cnt
`endif
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [N-1:0]  pick_grant;
  logic [PW-1:0] grant_idx;
  logic          pick_any;
  logic          hs;
  logic          sel_acc;
  logic [D-1:0]  sel_index;
  logic [W-1:0]  sel_data;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .valid     (req_valid & {N{arb_en}}),
    .ptr       (ptr),
    .grant     (pick_grant),
    .grant_idx (grant_idx),
    .any       (pick_any)
  );

  // Grant is only offered out of reset; a grant always implies a handshake.
  always_comb begin
    req_ready = pick_grant & {N{RST_N}};
    hs        = pick_any & RST_N;
    sel_acc   = req_acc[grant_idx];
    sel_index = req_index[grant_idx*D +: D];
    sel_data  = req_data[grant_idx*W +: W];
  end

  // Pointer advance and registered write strobes; index 0 is always an accumulator write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr        <= '0;
      RegWrite   <= 1'b0;
      AccWrite   <= 1'b0;
      reg_index  <= '0;
      writeValue <= '0;
    end else begin
      RegWrite <= 1'b0;
      AccWrite <= 1'b0;
      if (hs) begin
        ptr        <= (grant_idx == PW'(N-1)) ? '0 : grant_idx + 1'b1;
        writeValue <= sel_data;
        if (sel_acc || sel_index == '0) begin
          AccWrite  <= 1'b1;
          reg_index <= '0;
        end else begin
          RegWrite  <= 1'b1;
          reg_index <= sel_index;
        end
      end
    end
  end

`ifdef RF_ARB_STATS_EN
  // Per-requester handshake counters, saturating at all-ones.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && req_valid[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: fixed vector table, hand-written reset/stall
// sequences, then randomized traffic against a rotated-priority reference.
import rf_arb_pkg::*;

module tb_rf_write_arbiter;

  localparam int N = RF_ARB_N;
  localparam int W = RF_W;
  localparam int D = RF_D;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic           arb_en;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_acc;
  logic [N*D-1:0] req_index;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           RegWrite;
  logic           AccWrite;
  logic [D-1:0]   reg_index;
  logic [W-1:0]   writeValue;
`ifdef RF_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  rf_write_arbiter dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .arb_en     (arb_en),
    .req_valid  (req_valid),
    .req_acc    (req_acc),
    .req_index  (req_index),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .RegWrite   (RegWrite),
    .AccWrite   (AccWrite),
    .reg_index  (reg_index),
    .writeValue (writeValue)
`ifdef RF_ARB_STATS_EN
    ,.grant_cnt (grant_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  int        m_ptr;
  bit        m_rw, m_aw;
  int        m_idx, m_val;
  int        m_cnt [N];

  function automatic int ref_pick(bit en, logic [N-1:0] v, int p);
    if (!en) return -1;
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_rw = 0; m_aw = 0; m_idx = 0; m_val = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // Called just after a negedge: drive, check grant, clock, check registered write.
  task automatic apply(input bit en, input logic [N-1:0] v, input logic [N-1:0] acc,
                       input logic [N*D-1:0] idx, input logic [N*W-1:0] dat,
                       output int g);
    logic [N-1:0] exp_rdy;
    int ti;
    arb_en = en; req_valid = v; req_acc = acc; req_index = idx; req_data = dat;
    #1;
    g = ref_pick(en, v, m_ptr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge CLK); #1;
    m_rw = 0; m_aw = 0;
    if (g >= 0) begin
      m_cnt[g]++;
      m_ptr = (g + 1) % N;
      m_val = int'(dat[g*W +: W]);
      ti    = int'(idx[g*D +: D]);
      if (acc[g] || ti == 0) begin m_aw = 1; m_idx = 0; end
      else begin m_rw = 1; m_idx = ti; end
    end
    chk("RegWrite", 32'(RegWrite), 32'(m_rw));
    chk("AccWrite", 32'(AccWrite), 32'(m_aw));
    chk("reg_index", 32'(reg_index), 32'(m_idx));
    chk("writeValue", 32'(writeValue), 32'(m_val));
    @(negedge CLK);
  endtask

  typedef struct packed {
    logic           en;
    logic [N-1:0]   valid;
    logic [N-1:0]   acc;
    logic [N*D-1:0] idx;
    logic [N*W-1:0] data;
    logic [N-1:0]   e_rdy;
    logic           e_rw;
    logic           e_aw;
    logic [D-1:0]   e_idx;
    logic [W-1:0]   e_val;
  } vec_t;

  vec_t tv [12];

  function automatic vec_t mk(logic en, logic [N-1:0] v, logic [N-1:0] a, logic [N*D-1:0] i,
                              logic [N*W-1:0] d, logic [N-1:0] r, logic rw, logic aw,
                              logic [D-1:0] ei, logic [W-1:0] ev);
    vec_t t;
    t.en = en; t.valid = v; t.acc = a; t.idx = i; t.data = d;
    t.e_rdy = r; t.e_rw = rw; t.e_aw = aw; t.e_idx = ei; t.e_val = ev;
    return t;
  endfunction

  task automatic do_reset();
    RST_N = 1'b0; arb_en = 1'b1; req_valid = '1; req_acc = '0;
    req_index = {4'd7, 4'd5, 4'd3}; req_data = {8'h33, 8'h22, 8'h11};
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_RegWrite", 32'(RegWrite), 32'h0);
    chk("rst_AccWrite", 32'(AccWrite), 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
  endtask

  int g;
  logic [N-1:0]   pv, pa;
  logic [N*D-1:0] pi;
  logic [N*W-1:0] pd;
  bit             en_r;

  initial begin
    tv[0]  = mk(1, 3'b111, 3'b000, {4'd7,4'd5,4'd3}, {8'h33,8'h22,8'h11}, 3'b001, 1,0, 4'd3, 8'h11);
    tv[1]  = mk(1, 3'b111, 3'b000, {4'd7,4'd5,4'd3}, {8'h33,8'h22,8'h11}, 3'b010, 1,0, 4'd5, 8'h22);
    tv[2]  = mk(1, 3'b111, 3'b000, {4'd7,4'd5,4'd3}, {8'h33,8'h22,8'h11}, 3'b100, 1,0, 4'd7, 8'h33);
    tv[3]  = mk(1, 3'b010, 3'b010, {4'd7,4'd9,4'd3}, {8'h33,8'hA5,8'h11}, 3'b010, 0,1, 4'd0, 8'hA5);
    tv[4]  = mk(1, 3'b001, 3'b000, {4'd7,4'd9,4'd0}, {8'h33,8'hA5,8'h5A}, 3'b001, 0,1, 4'd0, 8'h5A);
    tv[5]  = mk(1, 3'b000, 3'b000, {4'd7,4'd9,4'd0}, {8'h33,8'hA5,8'h5A}, 3'b000, 0,0, 4'd0, 8'h5A);
    tv[6]  = mk(1, 3'b101, 3'b000, {4'd7,4'd5,4'd3}, {8'h33,8'h22,8'h11}, 3'b100, 1,0, 4'd7, 8'h33);
    tv[7]  = mk(1, 3'b101, 3'b000, {4'd7,4'd5,4'd3}, {8'h33,8'h22,8'h11}, 3'b001, 1,0, 4'd3, 8'h11);
    tv[8]  = mk(1, 3'b101, 3'b000, {4'd7,4'd5,4'd3}, {8'h33,8'h22,8'h11}, 3'b100, 1,0, 4'd7, 8'h33);
    tv[9]  = mk(1, 3'b101, 3'b000, {4'd7,4'd5,4'd3}, {8'h33,8'h22,8'h11}, 3'b001, 1,0, 4'd3, 8'h11);
    tv[10] = mk(0, 3'b111, 3'b000, {4'd7,4'd5,4'd3}, {8'h33,8'h22,8'h11}, 3'b000, 0,0, 4'd3, 8'h11);
    tv[11] = mk(1, 3'b111, 3'b000, {4'd7,4'd5,4'd3}, {8'h33,8'h22,8'h11}, 3'b010, 1,0, 4'd5, 8'h22);

    do_reset();

    // Table: burst, accumulator cases, fairness, stall and resume
    for (int t = 0; t < 12; t++) begin
      arb_en = tv[t].en; req_valid = tv[t].valid; req_acc = tv[t].acc;
      req_index = tv[t].idx; req_data = tv[t].data;
      #1;
      chk($sformatf("tv%0d_ready", t), 32'(req_ready), 32'(tv[t].e_rdy));
      @(posedge CLK); #1;
      chk($sformatf("tv%0d_RegWrite", t), 32'(RegWrite), 32'(tv[t].e_rw));
      chk($sformatf("tv%0d_AccWrite", t), 32'(AccWrite), 32'(tv[t].e_aw));
      chk($sformatf("tv%0d_reg_index", t), 32'(reg_index), 32'(tv[t].e_idx));
      chk($sformatf("tv%0d_writeValue", t), 32'(writeValue), 32'(tv[t].e_val));
      @(negedge CLK);
    end

    // Stall after first grant: one write issues, then none, then resume at 1
    do_reset();
    apply(1, 3'b111, 3'b000, {4'd7,4'd5,4'd3}, {8'h33,8'h22,8'h11}, g);
    apply(0, 3'b111, 3'b000, {4'd7,4'd5,4'd3}, {8'h33,8'h22,8'h11}, g);
    apply(0, 3'b111, 3'b000, {4'd7,4'd5,4'd3}, {8'h33,8'h22,8'h11}, g);
    arb_en = 1'b1; #1;
    chk("stall_resume_ready", 32'(req_ready), 32'h2);
    @(negedge CLK);

    // Asynchronous reset between clocks in the middle of a burst
    do_reset();
    apply(1, 3'b111, 3'b000, {4'd7,4'd5,4'd3}, {8'h33,8'h22,8'h11}, g);
    apply(1, 3'b111, 3'b000, {4'd7,4'd5,4'd3}, {8'h33,8'h22,8'h11}, g);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_RegWrite", 32'(RegWrite), 32'h0);
    chk("arst_reg_index", 32'(reg_index), 32'h0);
    chk("arst_writeValue", 32'(writeValue), 32'h0);
    chk("arst_ready", 32'(req_ready), 32'h0);
`ifdef RF_ARB_STATS_EN
    chk("arst_grant_cnt", 32'(grant_cnt), 32'h0);
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
    apply(1, 3'b111, 3'b000, {4'd7,4'd5,4'd3}, {8'h33,8'h22,8'h11}, g);
    chk("arst_restart_grant", 32'(g), 32'h0);

    // Randomized traffic; pending requests hold their payload until accepted
    do_reset();
    pv = '0; pa = '0; pi = '0; pd = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && ($urandom_range(0, 99) < 60)) begin
          pv[i]         = 1'b1;
          pa[i]         = ($urandom_range(0, 3) == 0);
          pi[i*D +: D]  = D'($urandom);
          pd[i*W +: W]  = W'($urandom);
        end
      end
      en_r = ($urandom_range(0, 9) != 0);
      apply(en_r, pv, pa, pi, pd, g);
      if (g >= 0) pv[g] = 1'b0;
    end
`ifdef RF_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      chk($sformatf("grant_cnt%0d", i), 32'(grant_cnt[i*16 +: 16]), 32'(m_cnt[i]));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
